// File: rtl/sdram_arbiter.sv
// Multi-client arbiter onto a single Avalon-MM SDRAM master, one transaction in flight.
// Define SDRAM_ARB_TIMEOUT_EN to abandon reads whose readdatavalid never arrives.
module sdram_arbiter #(
    parameter int NUM_CLIENTS    = 5,
    parameter int ADDR_W         = 23,
    parameter int DATA_W         = 32,
    parameter int RR_MODE        = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_CLIENTS-1:0]        i_req_read,
    input  logic [NUM_CLIENTS-1:0]        i_req_write,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] i_req_addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0] i_req_writedata,
    output logic [DATA_W-1:0]             o_readdata,
    output logic [NUM_CLIENTS-1:0]        o_finished,
    output logic                          o_timeout,
    output logic [ADDR_W-1:0]             o_sdram_address,
    output logic [3:0]                    o_sdram_byteenable_n,
    output logic                          o_sdram_chipselect,
    output logic [DATA_W-1:0]             o_sdram_writedata,
    output logic                          o_sdram_read_n,
    output logic                          o_sdram_write_n,
    input  logic [DATA_W-1:0]             i_sdram_readdata,
    input  logic                          i_sdram_readdatavalid,
    input  logic                          i_sdram_waitrequest,
    output logic [1:0]                    o_fsm_state
);

    localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Avalon handshake: the command is held on the bus while waitrequest is 1 and is
    // taken by the slave on the first edge where waitrequest is 0; readdatavalid is a
    // one-cycle strobe that is only honoured while a read is outstanding (WAIT_RD).

    state_t                 state;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       grant_idx;
    logic                   op_write;
    logic [NUM_CLIENTS-1:0] req_any;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_valid;
    logic [NUM_CLIENTS-1:0] grant_onehot;
    int                     j;

    assign req_any              = i_req_read | i_req_write;
    assign grant_onehot         = {{(NUM_CLIENTS-1){1'b0}}, 1'b1} << grant_idx;
    assign o_sdram_byteenable_n = 4'b0000;
    assign o_fsm_state          = state;

    // Winner search: rotate from rr_ptr in round-robin mode, else lowest index first.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        j          = 0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (RR_MODE != 0) begin
                j = int'(rr_ptr) + i;
                if (j >= NUM_CLIENTS) begin
                    j = j - NUM_CLIENTS;
                end
            end else begin
                j = i;
            end
            if (!pick_valid && req_any[j]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(j);
            end
        end
    end

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt;
`else
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state              <= IDLE;
            rr_ptr             <= '0;
            grant_idx          <= '0;
            op_write           <= 1'b0;
            o_finished         <= '0;
            o_readdata         <= '0;
            o_sdram_chipselect <= 1'b0;
            o_sdram_read_n     <= 1'b1;
            o_sdram_write_n    <= 1'b1;
            o_sdram_address    <= '0;
            o_sdram_writedata  <= '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
            o_timeout          <= 1'b0;
            to_cnt             <= '0;
`endif
        end else begin
            o_finished <= '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
            o_timeout  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_idx          <= pick_idx;
                        op_write           <= i_req_write[pick_idx];
                        o_sdram_chipselect <= 1'b1;
                        // Write wins when a client raises both strobes.
                        o_sdram_read_n     <= i_req_write[pick_idx];
                        o_sdram_write_n    <= ~i_req_write[pick_idx];
                        o_sdram_address    <= i_req_addr[pick_idx*ADDR_W +: ADDR_W];
                        o_sdram_writedata  <= i_req_writedata[pick_idx*DATA_W +: DATA_W];
                        if (RR_MODE != 0) begin
                            rr_ptr <= (pick_idx == IDX_W'(NUM_CLIENTS - 1)) ? '0 : pick_idx + 1'b1;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!i_sdram_waitrequest) begin
                        o_sdram_chipselect <= 1'b0;
                        o_sdram_read_n     <= 1'b1;
                        o_sdram_write_n    <= 1'b1;
                        o_sdram_address    <= '0;
                        o_sdram_writedata  <= '0;
                        if (op_write) begin
                            o_finished <= grant_onehot;
                            state      <= DONE;
                        end else begin
`ifdef SDRAM_ARB_TIMEOUT_EN
                            to_cnt <= '0;
`endif
                            state  <= WAIT_RD;
                        end
                    end
                end
                WAIT_RD: begin
                    if (i_sdram_readdatavalid) begin
                        o_readdata <= i_sdram_readdata;
                        o_finished <= grant_onehot;
                        state      <= DONE;
                    end
`ifdef SDRAM_ARB_TIMEOUT_EN
                    else if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        o_readdata <= '0;
                        o_timeout  <= 1'b1;
                        o_finished <= grant_onehot;
                        state      <= DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    // No grant here, so a client dropping its request on finished is safe.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: a round-robin and a fixed-priority instance share stimulus.
// Timeout vectors run only when SDRAM_ARB_TIMEOUT_EN is defined.
module tb_sdram_arbiter;

    localparam int N  = 5;
    localparam int AW = 23;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_read;
    logic [N-1:0]    req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_writedata;
    logic [DW-1:0]   sdram_readdata;
    logic            sdram_readdatavalid;
    logic            sdram_waitrequest;

    logic [DW-1:0] rr_readdata,  fp_readdata;
    logic [N-1:0]  rr_finished,  fp_finished;
    logic          rr_timeout,   fp_timeout;
    logic [AW-1:0] rr_addr,      fp_addr;
    logic [3:0]    rr_be_n,      fp_be_n;
    logic          rr_cs,        fp_cs;
    logic [DW-1:0] rr_wdata,     fp_wdata;
    logic          rr_read_n,    fp_read_n;
    logic          rr_write_n,   fp_write_n;
    logic [1:0]    rr_state,     fp_state;

    int n_checks = 0;
    int n_errs   = 0;

    logic [N-1:0] rr_exp_q[$];
    logic [N-1:0] fp_exp_q[$];

    // Clock and reset
    always #5 clk = ~clk;

    sdram_arbiter #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .TIMEOUT_CYCLES(16)) dut_rr (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_read(req_read), .i_req_write(req_write),
        .i_req_addr(req_addr), .i_req_writedata(req_writedata),
        .o_readdata(rr_readdata), .o_finished(rr_finished), .o_timeout(rr_timeout),
        .o_sdram_address(rr_addr), .o_sdram_byteenable_n(rr_be_n),
        .o_sdram_chipselect(rr_cs), .o_sdram_writedata(rr_wdata),
        .o_sdram_read_n(rr_read_n), .o_sdram_write_n(rr_write_n),
        .i_sdram_readdata(sdram_readdata), .i_sdram_readdatavalid(sdram_readdatavalid),
        .i_sdram_waitrequest(sdram_waitrequest), .o_fsm_state(rr_state)
    );

    sdram_arbiter #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .TIMEOUT_CYCLES(16)) dut_fp (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_read(req_read), .i_req_write(req_write),
        .i_req_addr(req_addr), .i_req_writedata(req_writedata),
        .o_readdata(fp_readdata), .o_finished(fp_finished), .o_timeout(fp_timeout),
        .o_sdram_address(fp_addr), .o_sdram_byteenable_n(fp_be_n),
        .o_sdram_chipselect(fp_cs), .o_sdram_writedata(fp_wdata),
        .o_sdram_read_n(fp_read_n), .o_sdram_write_n(fp_write_n),
        .i_sdram_readdata(sdram_readdata), .i_sdram_readdatavalid(sdram_readdatavalid),
        .i_sdram_waitrequest(sdram_waitrequest), .o_fsm_state(fp_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver tasks; inputs change just after the falling edge, outputs are sampled there too.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        req_read            = '0;
        req_write           = '0;
        req_addr            = '0;
        req_writedata       = '0;
        sdram_readdata      = '0;
        sdram_readdatavalid = 1'b0;
        sdram_waitrequest   = 1'b0;
    endtask

    task automatic set_req(input int k, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_write[k]            = wr;
        req_read[k]             = ~wr;
        req_addr[k*AW +: AW]    = a;
        req_writedata[k*DW +: DW] = d;
    endtask

    task automatic check_idle_bus(input string tag);
        check({tag, "_cs"},      rr_cs,      1'b0);
        check({tag, "_read_n"},  rr_read_n,  1'b1);
        check({tag, "_write_n"}, rr_write_n, 1'b1);
        check({tag, "_addr"},    rr_addr,    '0);
        check({tag, "_wdata"},   rr_wdata,   '0);
    endtask

    initial begin
        int early;
        logic [N-1:0] e;

        drive_idle();
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_state", rr_state, 2'd0);
        check("rst_fin", rr_finished, '0);
        check("rst_timeout", rr_timeout, 1'b0);
        check("rst_readdata", rr_readdata, '0);
        check("rst_be_n", rr_be_n, 4'h0);
        check_idle_bus("rst");
        rst_n = 1'b1;
        tick();

        // Client 2 write, no wait states: command at cycle 1, finished at cycle 2.
        set_req(2, 1'b1, 23'h000100, 32'hDEADBEEF);
        tick();
        check("wr_state", rr_state, 2'd1);
        check("wr_cs", rr_cs, 1'b1);
        check("wr_write_n", rr_write_n, 1'b0);
        check("wr_read_n", rr_read_n, 1'b1);
        check("wr_addr", rr_addr, 23'h000100);
        check("wr_wdata", rr_wdata, 32'hDEADBEEF);
        check("wr_fin_c1", rr_finished, '0);
        tick();
        check("wr_fin_rr", rr_finished, 5'b00100);
        check("wr_fin_fp", fp_finished, 5'b00100);
        check("wr_state_done", rr_state, 2'd3);
        check_idle_bus("wr_after");
        req_write = '0;
        tick();
        check("wr_fin_c3", rr_finished, '0);
        check("wr_state_idle", rr_state, 2'd0);

        // Client 0 read with three waitrequest cycles and a stray readdatavalid in ISSUE.
        set_req(0, 1'b0, 23'h000040, 32'hFFFF0000);
        sdram_waitrequest = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("rd_hold_state", rr_state, 2'd1);
            check("rd_hold_cs", rr_cs, 1'b1);
            check("rd_hold_read_n", rr_read_n, 1'b0);
            check("rd_hold_write_n", rr_write_n, 1'b1);
            check("rd_hold_addr", rr_addr, 23'h000040);
            check("rd_hold_fin", rr_finished, '0);
            sdram_readdatavalid = (i == 1);
            sdram_readdata      = (i == 1) ? 32'hBAD0BAD0 : 32'h0;
            if (i == 3) sdram_waitrequest = 1'b0;
            tick();
        end
        check("rd_wait_state", rr_state, 2'd2);
        check("rd_stray_ignored", rr_readdata, '0);
        check("rd_wait_fin", rr_finished, '0);
        check_idle_bus("rd_wait");
        tick();
        check("rd_wait2_fin", rr_finished, '0);
        sdram_readdatavalid = 1'b1;
        sdram_readdata      = 32'h12345678;
        tick();
        check("rd_data", rr_readdata, 32'h12345678);
        check("rd_fin_rr", rr_finished, 5'b00001);
        check("rd_fin_fp", fp_finished, 5'b00001);
        check("rd_no_timeout", rr_timeout, 1'b0);
        sdram_readdatavalid = 1'b0;
        req_read = '0;
        tick();
        check("rd_fin_clear", rr_finished, '0);
        check("rd_state_idle", rr_state, 2'd0);

`ifdef SDRAM_ARB_TIMEOUT_EN
        // Client 1 read that never completes: abandoned 17 cycles after acceptance.
        set_req(1, 1'b0, 23'h000155, 32'h0);
        sdram_waitrequest = 1'b0;
        tick();
        check("to_issue", rr_state, 2'd1);
        early = 0;
        for (int c = 2; c <= 17; c++) begin
            tick();
            if (rr_finished != '0) early++;
        end
        check("to_early", early, 0);
        check("to_still_wait", rr_state, 2'd2);
        tick();
        check("to_fin", rr_finished, 5'b00010);
        check("to_flag", rr_timeout, 1'b1);
        check("to_readdata", rr_readdata, '0);
        check("to_state_done", rr_state, 2'd3);
        req_read = '0;
        tick();
        check("to_flag_clear", rr_timeout, 1'b0);
        check("to_fin_clear", rr_finished, '0);
`endif

        // Reset while a read is outstanding; the late readdatavalid must be discarded.
        set_req(3, 1'b0, 23'h000077, 32'h0);
        sdram_waitrequest = 1'b0;
        tick();
        tick();
        check("rw_state_wait", rr_state, 2'd2);
        rst_n    = 1'b0;
        req_read = '0;
        tick();
        rst_n               = 1'b1;
        sdram_readdatavalid = 1'b1;
        sdram_readdata      = 32'hCAFEF00D;
        check("rw_state_rst", rr_state, 2'd0);
        tick();
        check("rw_fin", rr_finished, '0);
        check("rw_state_idle", rr_state, 2'd0);
        check("rw_readdata", rr_readdata, '0);
        check_idle_bus("rw");
        sdram_readdatavalid = 1'b0;
        tick();
        check("rw_fin2", rr_finished, '0);

        // Clients 0, 1 and 4 request continuously.
        set_req(0, 1'b1, 23'h000010, 32'h00000010);
        set_req(1, 1'b1, 23'h000011, 32'h00000011);
        set_req(4, 1'b1, 23'h000014, 32'h00000014);
        for (int r = 0; r < 2; r++) begin
            rr_exp_q.push_back(5'b00001);
            rr_exp_q.push_back(5'b00010);
            rr_exp_q.push_back(5'b10000);
            for (int k = 0; k < 3; k++) fp_exp_q.push_back(5'b00001);
        end
        for (int c = 0; c < 60; c++) begin
            tick();
            if (rr_finished != '0) begin
                if (rr_exp_q.size() > 0) begin
                    e = rr_exp_q.pop_front();
                    check("rr_grant", rr_finished, e);
                end else begin
                    check("rr_extra", rr_finished, '0);
                end
            end
            if (fp_finished != '0) begin
                if (fp_exp_q.size() > 0) begin
                    e = fp_exp_q.pop_front();
                    check("fp_grant", fp_finished, e);
                end else begin
                    check("fp_extra", fp_finished, '0);
                end
            end
            if (rr_exp_q.size() == 0 && fp_exp_q.size() == 0) break;
        end
        check("rr_missing", rr_exp_q.size(), 0);
        check("fp_missing", fp_exp_q.size(), 0);
        drive_idle();
        tick();
        tick();
        check("arb_end_rr_state", rr_state, 2'd0);
        check("arb_end_fp_state", fp_state, 2'd0);
        check("arb_end_fp_cs", fp_cs, 1'b0);
        check_idle_bus("arb_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_CLIENTS, default 5: number of requesting cores (legal range 2..8).
REQ-002 The module SHALL have parameter ADDR_W, default 23: SDRAM word address width.
REQ-003 The module SHALL have parameter DATA_W, default 32: data width.
REQ-004 The module SHALL have parameter RR_MODE, default 1: 1 selects round-robin arbitration, 0 selects fixed priority (lowest index wins).
REQ-005 The module SHALL have parameter TIMEOUT_CYCLES, default 1024: read-data wait limit, used only with SDRAM_ARB_TIMEOUT_EN.
REQ-006 The module SHALL have port i_clk, input, 1: the single clock.
REQ-007 The module SHALL have port i_rst_n, input, 1: reset, synchronous and active-low.
REQ-008 The module SHALL have port i_req_read, input, NUM_CLIENTS: per-client read request, held level until that client's finished pulse.
REQ-009 The module SHALL have port i_req_write, input, NUM_CLIENTS: per-client write request, held level until that client's finished pulse.
REQ-010 The module SHALL have port i_req_addr, input, NUM_CLIENTS*ADDR_W: per-client addresses, client k at bits [k*ADDR_W +: ADDR_W].
REQ-011 The module SHALL have port i_req_writedata, input, NUM_CLIENTS*DATA_W: per-client write data, packed the same way as i_req_addr.
REQ-012 The module SHALL have port o_readdata, output, DATA_W: read data, shared by all clients and valid while o_finished is set.
REQ-013 The module SHALL have port o_finished, output, NUM_CLIENTS: one-cycle, one-hot completion pulse.
REQ-014 The module SHALL have port o_timeout, output, 1: pulses together with o_finished when a read is abandoned.
REQ-015 The module SHALL have ports o_sdram_address (ADDR_W), o_sdram_byteenable_n (4), o_sdram_chipselect (1), o_sdram_writedata (DATA_W), o_sdram_read_n (1) and o_sdram_write_n (1), all outputs, forming the Avalon-MM master side.
REQ-016 The module SHALL have ports i_sdram_readdata (DATA_W), i_sdram_readdatavalid (1) and i_sdram_waitrequest (1), all inputs.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT_RD and DONE, with a single transaction outstanding at any time.
REQ-018 In IDLE, the block SHALL select a winner whenever any i_req_read or i_req_write bit is set, latch its index, op, address and write data, and move to ISSUE on the next cycle.
REQ-019 In round-robin mode, the search SHALL start at a pointer that resets to 0; after a grant to client k the pointer SHALL become (k+1) mod NUM_CLIENTS.
REQ-020 In fixed-priority mode, the lowest set index SHALL win.
REQ-021 If a client asserts both read and write, write SHALL take precedence and the read SHALL be ignored for that grant.
REQ-022 In ISSUE, chipselect SHALL be 1, read_n or write_n SHALL be 0 per the latched op, and address and writedata SHALL come from the latches; all of these SHALL be held unchanged while waitrequest is 1.
REQ-023 In ISSUE with waitrequest 0, a write SHALL go to DONE and a read SHALL go to WAIT_RD.
REQ-024 In WAIT_RD, on readdatavalid the block SHALL register i_sdram_readdata into o_readdata and go to DONE.
REQ-025 The block SHALL ignore readdatavalid in every state other than WAIT_RD.
REQ-026 In DONE, o_finished[grant] SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE; no new grant is made in DONE, so a client that drops its request on seeing finished is never re-granted.
REQ-027 Outside ISSUE, the idle Avalon values SHALL be: chipselect 0, read_n 1, write_n 1, address 0, writedata 0.
REQ-028 o_sdram_byteenable_n SHALL be 0 at all times.
REQ-029 Write latency SHALL be: request in IDLE at cycle 0, command at cycle 1, finished at cycle 2 when waitrequest is 0.
REQ-030 Read latency SHALL be: readdatavalid at cycle t puts finished and o_readdata at cycle t+1.
REQ-031 A request withdrawn before it is granted SHALL be dropped, with no finished pulse.

Reset
REQ-032 When i_rst_n is 0 at a clock edge, the block SHALL go to IDLE with round-robin pointer 0, o_finished 0, o_timeout 0, o_readdata 0, Avalon outputs at their idle values, and the timeout counter 0.
REQ-033 A reset during ISSUE or WAIT_RD SHALL abort the transaction without a finished pulse; late readdatavalid arriving after the reset SHALL be discarded.

Configuration
REQ-034 When SDRAM_ARB_TIMEOUT_EN is defined, a counter SHALL clear on entering WAIT_RD and increment every cycle spent in WAIT_RD.
REQ-035 When SDRAM_ARB_TIMEOUT_EN is defined and the counter reaches TIMEOUT_CYCLES-1 without readdatavalid, the block SHALL go to DONE with o_readdata = 0 and o_timeout = 1 during DONE.
REQ-036 When SDRAM_ARB_TIMEOUT_EN is not defined, the counter SHALL be absent, o_timeout SHALL be tied to 0, and WAIT_RD SHALL wait indefinitely.

Verification
REQ-037 The bench SHALL cover: client 2 writes 0xDEADBEEF to address 0x000100 with waitrequest 0 -> write_n low at cycle 1, o_finished = 5'b00100 at cycle 2.
REQ-038 The bench SHALL cover: client 0 reads 0x000040, waitrequest held 3 cycles, readdatavalid with 0x12345678 two cycles later -> command held steady for all waitrequest cycles, o_readdata = 0x12345678 with o_finished[0] one cycle after readdatavalid.
REQ-039 The bench SHALL cover: RR_MODE = 1 with clients 0, 1 and 4 requesting continuously -> grant order 0, 1, 4, 0, 1, 4.
REQ-040 The bench SHALL cover: the same stimulus as REQ-039 with RR_MODE = 0 -> all grants to client 0 while it requests.
REQ-041 The bench SHALL cover: i_rst_n low for one cycle in WAIT_RD, then readdatavalid -> no finished pulse, FSM in IDLE, Avalon outputs idle.
REQ-042 The bench SHALL cover: with SDRAM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 16, a read that never gets readdatavalid -> finished and o_timeout together 17 cycles after the command is accepted, o_readdata = 0.
